// File: rtl/ft60x_device_emu_if.sv
// FT60x device-side bus bundle: 245-style synchronous FIFO pins plus the host-side streams.
// Latency: none (wires only).
// Backpressure: carries RXF_N/TXE_N towards the FIFO master and valid/accept on the host streams.
//
// Modports:
//   slave  - the device emulator (drives RXF_N/TXE_N, read data, inport_accept, outport).
//   master - the FIFO master plus host side (drives strobes, write data, inport, outport_accept).
interface ft60x_device_emu_if;
    // FT60x FIFO bus
    logic        ftdi_wrn_i;
    logic        ftdi_rdn_i;
    logic        ftdi_oen_i;
    logic [31:0] ftdi_data_in_i;
    logic [3:0]  ftdi_be_in_i;
    logic        ftdi_rxf_o;
    logic        ftdi_txe_o;
    logic [31:0] ftdi_data_out_o;
    logic [3:0]  ftdi_be_out_o;
    logic        ftdi_data_oe_o;
    // host -> master stream
    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic        inport_accept_o;
    // master -> host stream
    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic [3:0]  outport_be_o;
    logic        outport_accept_i;

    modport slave (
        input  ftdi_wrn_i, ftdi_rdn_i, ftdi_oen_i, ftdi_data_in_i, ftdi_be_in_i,
        output ftdi_rxf_o, ftdi_txe_o, ftdi_data_out_o, ftdi_be_out_o, ftdi_data_oe_o,
        input  inport_valid_i, inport_data_i,
        output inport_accept_o,
        output outport_valid_o, outport_data_o, outport_be_o,
        input  outport_accept_i
    );

    modport master (
        output ftdi_wrn_i, ftdi_rdn_i, ftdi_oen_i, ftdi_data_in_i, ftdi_be_in_i,
        input  ftdi_rxf_o, ftdi_txe_o, ftdi_data_out_o, ftdi_be_out_o, ftdi_data_oe_o,
        output inport_valid_i, inport_data_i,
        input  inport_accept_o,
        input  outport_valid_o, outport_data_o, outport_be_o,
        output outport_accept_i
    );
endinterface

// File: rtl/ft60x_device_emu.sv
// FT60x device emulator: host stream -> RX buffer -> FIFO master reads; master writes -> TX buffer -> host stream.
// Latency: one cycle from inport push to RXF_N low; one cycle from a captured write to outport_valid.
// Backpressure: RXF_N/TXE_N are registered from the next buffer state; inport_accept drops at RX full.
//
// Ports: clk_i (shared with the FT60x bus), rst_i (synchronous, active high),
//        bus (ft60x_device_emu_if.slave: FIFO bus pins, inport and outport streams).
// Optional build macro: FT60X_DEVICE_EMU_THROTTLE_EN adds LFSR-driven USB-side stalls on RXF_N/TXE_N.
module ft60x_device_emu #(
    parameter int RX_DEPTH_W = 9,
    parameter int TX_DEPTH_W = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ft60x_device_emu_if.slave   bus
);
    localparam int RX_DEPTH = 1 << RX_DEPTH_W;
    localparam int TX_DEPTH = 1 << TX_DEPTH_W;
    localparam logic [RX_DEPTH_W:0] RX_FULL = {1'b1, {RX_DEPTH_W{1'b0}}};
    localparam logic [TX_DEPTH_W:0] TX_FULL = {1'b1, {TX_DEPTH_W{1'b0}}};

    // Stall requests for the coming cycle; folded into the registered flags.
    logic rx_stall_nxt;
    logic tx_stall_nxt;

`ifdef FT60X_DEVICE_EMU_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_nxt;
    end

    // Flags are registered from lfsr_nxt so each stall lines up with lfsr_q in the same cycle.
    assign tx_stall_nxt = (lfsr_nxt[1:0] == 2'b00);
    assign rx_stall_nxt = (lfsr_nxt[3:2] == 2'b00);
`else
    assign tx_stall_nxt = 1'b0;
    assign rx_stall_nxt = 1'b0;
`endif

    // ---------------- RX: host -> master ----------------
    // The head word lives in rx_head_q; rx_mem holds the words behind it.
    // rx_level_q counts both, so the memory occupancy is level minus the head.
    logic [31:0]           rx_mem [RX_DEPTH];
    logic [RX_DEPTH_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RX_DEPTH_W:0]   rx_level_q, rx_mem_cnt;
    logic [31:0]           rx_head_q;
    logic                  rx_head_vld_q, rxf_q;
    logic                  rx_push, rx_pop, rx_refill, rx_mem_rd, rx_bypass, rx_mem_wr, rx_head_vld_nxt;

    assign bus.inport_accept_o = (rx_level_q != RX_FULL);
    assign rx_push    = bus.inport_valid_i && bus.inport_accept_o;
    assign rx_pop     = !bus.ftdi_rdn_i && !bus.ftdi_oen_i && !rxf_q;
    assign rx_mem_cnt = rx_level_q - (RX_DEPTH_W + 1)'(rx_head_vld_q);
    // Head slot is free (or being vacated): refill from memory, else take an incoming word directly.
    assign rx_refill  = !rx_head_vld_q || rx_pop;
    assign rx_mem_rd  = rx_refill && (rx_mem_cnt != '0);
    assign rx_bypass  = rx_refill && (rx_mem_cnt == '0) && rx_push;
    assign rx_mem_wr  = rx_push && !rx_bypass;
    assign rx_head_vld_nxt = (rx_head_vld_q && !rx_pop) || rx_mem_rd || rx_bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_level_q    <= '0;
            rx_head_q     <= '0;
            rx_head_vld_q <= 1'b0;
            rxf_q         <= 1'b1;
        end else begin
            if (rx_mem_wr) rx_wr_ptr_q <= rx_wr_ptr_q + RX_DEPTH_W'(1);
            if (rx_mem_rd) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + RX_DEPTH_W'(1);
                rx_head_q   <= rx_mem[rx_rd_ptr_q];
            end else if (rx_bypass) begin
                rx_head_q   <= bus.inport_data_i;
            end
            rx_level_q    <= rx_level_q + (RX_DEPTH_W + 1)'(rx_push) - (RX_DEPTH_W + 1)'(rx_pop);
            rx_head_vld_q <= rx_head_vld_nxt;
            // Rises on the edge that pops the last word, so the master never sees a stale head.
            rxf_q         <= !rx_head_vld_nxt || rx_stall_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_mem_wr) rx_mem[rx_wr_ptr_q] <= bus.inport_data_i;
    end

    assign bus.ftdi_rxf_o      = rxf_q;
    assign bus.ftdi_data_oe_o  = !bus.ftdi_oen_i;
    assign bus.ftdi_data_out_o = bus.ftdi_oen_i ? 32'h0 : rx_head_q;
    assign bus.ftdi_be_out_o   = bus.ftdi_oen_i ? 4'h0 : 4'hF;

    // ---------------- TX: master -> host ----------------
    logic [35:0]           tx_mem [TX_DEPTH];
    logic [TX_DEPTH_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TX_DEPTH_W:0]   tx_level_q, tx_level_nxt;
    logic                  txe_q, tx_wr, tx_pop, tx_vld;

    assign tx_vld       = (tx_level_q != '0);
    assign tx_wr        = !bus.ftdi_wrn_i && !txe_q;
    assign tx_pop       = tx_vld && bus.outport_accept_i;
    assign tx_level_nxt = tx_level_q + (TX_DEPTH_W + 1)'(tx_wr) - (TX_DEPTH_W + 1)'(tx_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
            txe_q       <= 1'b1;
        end else begin
            if (tx_wr)  tx_wr_ptr_q <= tx_wr_ptr_q + TX_DEPTH_W'(1);
            if (tx_pop) tx_rd_ptr_q <= tx_rd_ptr_q + TX_DEPTH_W'(1);
            tx_level_q <= tx_level_nxt;
            // Closing on the filling write makes overflow impossible without a combinational TXE_N.
            txe_q      <= (tx_level_nxt == TX_FULL) || tx_stall_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_wr) tx_mem[tx_wr_ptr_q] <= {bus.ftdi_be_in_i, bus.ftdi_data_in_i};
    end

    assign bus.ftdi_txe_o      = txe_q;
    assign bus.outport_valid_o = tx_vld;
    // Zero while empty so stale memory never shows on the stream.
    assign {bus.outport_be_o, bus.outport_data_o} = tx_vld ? tx_mem[tx_rd_ptr_q] : 36'h0;
endmodule

// File: tb/tb_ft60x_device_emu.sv
// Testbench for ft60x_device_emu with 4-entry RX and TX buffers.
// Stimulus tasks push expected words into per-direction queues; a negedge monitor pops and compares.
// Directed checks cover reset, flag timing at empty/full, wrap-around and reset during a read burst.
module tb_ft60x_device_emu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ft60x_device_emu_if bus();

    ft60x_device_emu #(
        .RX_DEPTH_W (2),
        .TX_DEPTH_W (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int ntests = 0;
    int nfail  = 0;
    int rx_pops = 0;
    int tx_pops = 0;
    logic [31:0] rx_exp[$];
    logic [35:0] tx_exp[$];
    logic        stop_feed = 1'b0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer happens on the next posedge when these conditions hold.
    always @(negedge clk) begin : monitor
        logic [31:0] e32;
        logic [35:0] e36;
        if (!rst) begin
            if (!bus.ftdi_rdn_i && !bus.ftdi_oen_i && !bus.ftdi_rxf_o) begin
                rx_pops++;
                if (rx_exp.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL rx_unexpected: got 0x%h, no word expected", bus.ftdi_data_out_o);
                end else begin
                    e32 = rx_exp.pop_front();
                    chk("rx_word", {bus.ftdi_be_out_o, bus.ftdi_data_out_o}, {4'hF, e32});
                end
            end
            if (bus.outport_valid_o && bus.outport_accept_i) begin
                tx_pops++;
                if (tx_exp.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL tx_unexpected: got 0x%h, no word expected", bus.outport_data_o);
                end else begin
                    e36 = tx_exp.pop_front();
                    chk("tx_word", {bus.outport_be_o, bus.outport_data_o}, e36);
                end
            end
        end
    end

    // Host pushes one word; called and returns just after a posedge.
    task automatic host_send(input logic [31:0] d);
        bus.inport_valid_i = 1'b1;
        bus.inport_data_i  = d;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (bus.inport_accept_o) begin
                if (!rst) rx_exp.push_back(d);
                break;
            end
            if (t == 500) begin
                ntests++; nfail++;
                $display("FAIL host_send_timeout: accept stayed 0, required 1");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.inport_valid_i = 1'b0;
    endtask

    // Master writes one word after gap idle cycles, holding it until TXE_N allows capture.
    task automatic ft_write(input logic [31:0] d, input logic [3:0] be, input int gap);
        bus.ftdi_wrn_i = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
        bus.ftdi_wrn_i     = 1'b0;
        bus.ftdi_data_in_i = d;
        bus.ftdi_be_in_i   = be;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (!bus.ftdi_txe_o) begin
                tx_exp.push_back({be, d});
                @(posedge clk); #1;
                return;
            end
            if (t == 500) begin
                ntests++; nfail++;
                $display("FAIL ft_write_timeout: txe stayed 1, required 0");
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc;
        int base_rx;
        int base_tx;
        bus.ftdi_wrn_i = 1'b1; bus.ftdi_rdn_i = 1'b1; bus.ftdi_oen_i = 1'b1;
        bus.ftdi_data_in_i = 32'h0; bus.ftdi_be_in_i = 4'h0;
        bus.inport_valid_i = 1'b0; bus.inport_data_i = 32'h0;
        bus.outport_accept_i = 1'b0;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rxf",   36'(bus.ftdi_rxf_o), 36'd1);
        chk("rst_txe",   36'(bus.ftdi_txe_o), 36'd1);
        chk("rst_valid", 36'(bus.outport_valid_o), 36'd0);
        chk("rst_out",   {bus.outport_be_o, bus.outport_data_o}, 36'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_txe",    36'(bus.ftdi_txe_o), 36'd0);
        chk("post_rst_rxf",    36'(bus.ftdi_rxf_o), 36'd1);
        chk("post_rst_accept", 36'(bus.inport_accept_o), 36'd1);
        @(posedge clk); #1;

        // ---- RX burst ----
        host_send(32'h11); host_send(32'h22); host_send(32'h33);
        bus.ftdi_oen_i = 1'b0;
        @(negedge clk);
        chk("rx_oe_on",   36'(bus.ftdi_data_oe_o), 36'd1);
        chk("rx_head",    {bus.ftdi_be_out_o, bus.ftdi_data_out_o}, {4'hF, 32'h11});
        @(posedge clk); #1;
        bus.ftdi_rdn_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.ftdi_rdn_i = 1'b1;
        @(negedge clk);
        chk("rx_last_pop_rxf", 36'(bus.ftdi_rxf_o), 36'd1);
        @(posedge clk); #1;
        bus.ftdi_oen_i = 1'b1;
        @(negedge clk);
        chk("rx_oe_off",  36'(bus.ftdi_data_oe_o), 36'd0);
        chk("rx_bus_off", {bus.ftdi_be_out_o, bus.ftdi_data_out_o}, 36'd0);
        chk("rx_burst_left", 36'(rx_exp.size()), 36'd0);
        @(posedge clk); #1;

        // ---- RX full ----
        for (int i = 0; i < 4; i++) host_send(32'h60 + 32'(i));
        @(negedge clk);
        chk("rx_full_accept", 36'(bus.inport_accept_o), 36'd0);
        @(posedge clk); #1;
        bus.ftdi_oen_i = 1'b0; bus.ftdi_rdn_i = 1'b0;
        for (int t = 0; t < 50 && rx_exp.size() != 0; t++) @(posedge clk);
        #1 bus.ftdi_rdn_i = 1'b1; bus.ftdi_oen_i = 1'b1;
        @(negedge clk);
        chk("rx_full_drained", 36'(rx_exp.size()), 36'd0);
        chk("rx_full_rxf",     36'(bus.ftdi_rxf_o), 36'd1);
        @(posedge clk); #1;

        // ---- TX burst ----
        bus.outport_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) ft_write(32'hA0 + 32'(i), 4'hF, 0);
        bus.ftdi_wrn_i = 1'b1;
        for (int t = 0; t < 50 && tx_exp.size() != 0; t++) @(posedge clk);
        #1 chk("tx_burst_drained", 36'(tx_exp.size()), 36'd0);
        bus.outport_accept_i = 1'b0;
        @(posedge clk); #1;

        // ---- TX full: four entries, master keeps retrying ----
        for (int i = 0; i < 4; i++) tx_exp.push_back({4'hF, 32'hB0 + 32'(i)});
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.ftdi_wrn_i = 1'b0; bus.ftdi_be_in_i = 4'hF;
            bus.ftdi_data_in_i = 32'hB0 + 32'(nacc);
            @(negedge clk);
            chk("tx_full_txe", 36'(bus.ftdi_txe_o), (c >= 4) ? 36'd1 : 36'd0);
            if (!bus.ftdi_txe_o) nacc++;
            @(posedge clk); #1;
        end
        bus.ftdi_wrn_i = 1'b1;
        chk("tx_full_stored", 36'(nacc), 36'd4);
        @(negedge clk);
        chk("tx_full_hold", {bus.outport_be_o, bus.outport_data_o}, {4'hF, 32'hB0});
        @(posedge clk); #1;
        bus.outport_accept_i = 1'b1;
        @(negedge clk);
        chk("tx_full_txe_prepop", 36'(bus.ftdi_txe_o), 36'd1);
        @(posedge clk);
        @(negedge clk);
        chk("tx_free_txe", 36'(bus.ftdi_txe_o), 36'd0);
        for (int t = 0; t < 50 && tx_exp.size() != 0; t++) @(posedge clk);
        #1 chk("tx_full_drained", 36'(tx_exp.size()), 36'd0);
        bus.outport_accept_i = 1'b0;
        @(posedge clk); #1;

        // ---- wrap-around: 3x depth each direction with random gaps ----
        base_rx = rx_pops;
        base_tx = tx_pops;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    host_send(32'h1000 + 32'(i));
                end
            end
            begin
                for (int i = 0; i < 12; i++)
                    ft_write(32'h2000 + 32'(i), 4'(i) | 4'h1, int'($urandom_range(0, 2)));
                bus.ftdi_wrn_i = 1'b1;
            end
            begin
                bus.ftdi_oen_i = 1'b0;
                for (int t = 0; t < 3000 && rx_pops - base_rx < 12; t++) begin
                    bus.ftdi_rdn_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.ftdi_rdn_i = 1'b1; bus.ftdi_oen_i = 1'b1;
            end
            begin
                for (int t = 0; t < 3000 && tx_pops - base_tx < 12; t++) begin
                    bus.outport_accept_i = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.outport_accept_i = 1'b0;
            end
        join
        chk("wrap_rx_count", 36'(rx_pops - base_rx), 36'd12);
        chk("wrap_tx_count", 36'(tx_pops - base_tx), 36'd12);
        chk("wrap_rx_left",  36'(rx_exp.size()), 36'd0);
        chk("wrap_tx_left",  36'(tx_exp.size()), 36'd0);

        // ---- reset during a 10-word read ----
        base_rx = rx_pops;
        stop_feed = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (stop_feed) break;
                    host_send(32'h50 + 32'(i));
                end
            end
            begin
                bus.ftdi_oen_i = 1'b0; bus.ftdi_rdn_i = 1'b0;
                for (int t = 0; t < 200 && rx_pops - base_rx < 3; t++) @(posedge clk);
                #1;
                rst = 1'b1;
                stop_feed = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("rst_mid_rxf", 36'(bus.ftdi_rxf_o), 36'd1);
                @(posedge clk); #1;
            end
        join
        rx_exp.delete();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_rxf_hold", 36'(bus.ftdi_rxf_o), 36'd1);
            @(posedge clk); #1;
        end
        chk("rst_mid_pops", 36'(rx_pops - base_rx), 36'd3);
        bus.ftdi_rdn_i = 1'b1; bus.ftdi_oen_i = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
